// File: rtl/lock_sequencer.sv
// Canal lock transit sequencer: arbitrates outer/inner requests, equalises the lock,
// cycles the source gate, transfers water level, then cycles the destination gate.
module lock_sequencer #(
  parameter int DATA_W        = 8,
  parameter int TOL           = 2,
  parameter int GATE_CYCLES   = 16,
  parameter int DWELL_CYCLES  = 64,
  parameter int WATER_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_outer,
  input  logic              req_inner,
  input  logic [DATA_W-1:0] lock_level,
  input  logic [DATA_W-1:0] outer_level,
  input  logic [DATA_W-1:0] inner_level,
  input  logic              outer_closed,
  input  logic              inner_closed,
  output logic              outer_cmd,
  output logic              inner_cmd,
  output logic              fill,
  output logic              drain,
  output logic              grant_outer,
  output logic              grant_inner,
  output logic              busy,
  output logic              fault,
  output logic [3:0]        state
);

  localparam int LW = DATA_W + 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    EQ      = 4'd1,
    OPEN_A  = 4'd2,
    DWELL_A = 4'd3,
    CLOSE_A = 4'd4,
    XFER    = 4'd5,
    OPEN_B  = 4'd6,
    DWELL_B = 4'd7,
    CLOSE_B = 4'd8,
    FAULT   = 4'd9
  } state_t;

  function automatic logic lvl_match(input logic [DATA_W-1:0] lvl, input logic [DATA_W-1:0] tgt);
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic [LW-1:0] d;
    a = {1'b0, lvl};
    b = {1'b0, tgt};
    d = (a >= b) ? (a - b) : (b - a);
    return d <= LW'(TOL);
  endfunction

  function automatic logic lvl_below(input logic [DATA_W-1:0] lvl, input logic [DATA_W-1:0] tgt);
    return ({1'b0, lvl} + LW'(TOL)) < {1'b0, tgt};
  endfunction

  function automatic logic lvl_above(input logic [DATA_W-1:0] lvl, input logic [DATA_W-1:0] tgt);
    return {1'b0, lvl} > ({1'b0, tgt} + LW'(TOL));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] t);
    return (t == 16'hFFFF) ? t : t + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] timer_q;
  logic        pend_outer_q, pend_inner_q;
  logic        last_inner_q, last_d;
  logic        side_inner_q, side_d;
  logic        grant_q, grant_d;
  logic        fill_q, drain_q, fill_d, drain_d;
  logic        outer_cmd_q, inner_cmd_q;
  logic        take_outer, take_inner;
  logic        gates_closed;
  logic        src_closed, dst_closed;
  logic [DATA_W-1:0] src_lvl, dst_lvl;
  logic        phase_a_open, phase_b_open;
  logic        open_outer, open_inner;

  // Round robin: on a tie the side that was not served last wins.
  assign take_outer   = pend_outer_q & (~pend_inner_q | last_inner_q);
  assign take_inner   = pend_inner_q & (~pend_outer_q | ~last_inner_q);
  assign gates_closed = outer_closed & inner_closed;
  assign src_lvl      = side_inner_q ? inner_level  : outer_level;
  assign dst_lvl      = side_inner_q ? outer_level  : inner_level;
  assign src_closed   = side_inner_q ? inner_closed : outer_closed;
  assign dst_closed   = side_inner_q ? outer_closed : inner_closed;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    side_d  = side_inner_q;
    last_d  = last_inner_q;
    fill_d  = 1'b0;
    drain_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_outer || take_inner) begin
          state_d = EQ;
          grant_d = 1'b1;
          side_d  = take_inner;
          last_d  = take_inner;
        end
      end
      EQ: begin
        if (!gates_closed)                               state_d = FAULT;
        else if (lvl_match(lock_level, src_lvl))         state_d = OPEN_A;
        else if (timer_q >= 16'(WATER_TIMEOUT))          state_d = FAULT;
        else begin
          fill_d  = lvl_below(lock_level, src_lvl);
          drain_d = lvl_above(lock_level, src_lvl);
        end
      end
      OPEN_A: begin
        if (!src_closed)                                 state_d = DWELL_A;
        else if (timer_q >= 16'(GATE_CYCLES))            state_d = FAULT;
      end
      DWELL_A: begin
        if (timer_q >= 16'(DWELL_CYCLES - 1))            state_d = CLOSE_A;
      end
      CLOSE_A: begin
        if (src_closed)                                  state_d = XFER;
        else if (timer_q >= 16'(GATE_CYCLES))            state_d = FAULT;
      end
      XFER: begin
        if (!gates_closed)                               state_d = FAULT;
        else if (lvl_match(lock_level, dst_lvl))         state_d = OPEN_B;
        else if (timer_q >= 16'(WATER_TIMEOUT))          state_d = FAULT;
        else begin
          fill_d  = lvl_below(lock_level, dst_lvl);
          drain_d = lvl_above(lock_level, dst_lvl);
        end
      end
      OPEN_B: begin
        if (!dst_closed)                                 state_d = DWELL_B;
        else if (timer_q >= 16'(GATE_CYCLES))            state_d = FAULT;
      end
      DWELL_B: begin
        if (timer_q >= 16'(DWELL_CYCLES - 1))            state_d = CLOSE_B;
      end
      CLOSE_B: begin
        if (dst_closed) begin
          state_d = IDLE;
          grant_d = 1'b0;
        end else if (timer_q >= 16'(GATE_CYCLES)) begin
          state_d = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    if (state_d == FAULT) begin
      grant_d = 1'b0;
      fill_d  = 1'b0;
      drain_d = 1'b0;
    end
  end

  // Gate commands are decoded from the next state so they change with the state register.
  assign phase_a_open = (state_d == OPEN_A) || (state_d == DWELL_A);
  assign phase_b_open = (state_d == OPEN_B) || (state_d == DWELL_B);
  assign open_outer   = (phase_a_open && !side_d) || (phase_b_open &&  side_d);
  assign open_inner   = (phase_a_open &&  side_d) || (phase_b_open && !side_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      timer_q      <= 16'd0;
      pend_outer_q <= 1'b0;
      pend_inner_q <= 1'b0;
      last_inner_q <= 1'b1;
      side_inner_q <= 1'b0;
      grant_q      <= 1'b0;
      fill_q       <= 1'b0;
      drain_q      <= 1'b0;
      outer_cmd_q  <= 1'b1;
      inner_cmd_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= (state_d != state_q) ? 16'd0 : sat_inc(timer_q);
      pend_outer_q <= (state_q == IDLE && take_outer) ? 1'b0 : (pend_outer_q | req_outer);
      pend_inner_q <= (state_q == IDLE && take_inner) ? 1'b0 : (pend_inner_q | req_inner);
      last_inner_q <= last_d;
      side_inner_q <= side_d;
      grant_q      <= grant_d;
      fill_q       <= fill_d & ~drain_d;
      drain_q      <= drain_d & ~fill_d;
      outer_cmd_q  <= ~open_outer;
      inner_cmd_q  <= ~open_inner;
    end
  end

  // Water moves only with both gates commanded and reported closed, checked live so a
  // gate dropping open cuts fill/drain in the same cycle rather than one cycle later.
  assign fill        = fill_q  & gates_closed & outer_cmd_q & inner_cmd_q;
  assign drain       = drain_q & gates_closed & outer_cmd_q & inner_cmd_q;
  assign outer_cmd   = outer_cmd_q;
  assign inner_cmd   = inner_cmd_q;
  assign grant_outer = grant_q & ~side_inner_q;
  assign grant_inner = grant_q &  side_inner_q;
  assign busy        = (state_q != IDLE);
  assign fault       = (state_q == FAULT);
  assign state       = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a simple lock/gate plant model.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_outer, req_inner;
  logic [7:0] lock_level, outer_level, inner_level;
  logic       outer_closed, inner_closed;
  logic       outer_cmd, inner_cmd, fill, drain;
  logic       grant_outer, grant_inner, busy, fault;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int cnt [16];
  int fill_cnt, drain_cnt, ocmd_lo, icmd_lo, viol;
  logic [7:0] min_lock;
  bit freeze, stuck_outer;

  always #5 clk = ~clk;

  lock_sequencer dut (
    .clk(clk), .rst(rst),
    .req_outer(req_outer), .req_inner(req_inner),
    .lock_level(lock_level), .outer_level(outer_level), .inner_level(inner_level),
    .outer_closed(outer_closed), .inner_closed(inner_closed),
    .outer_cmd(outer_cmd), .inner_cmd(inner_cmd),
    .fill(fill), .drain(drain),
    .grant_outer(grant_outer), .grant_inner(grant_inner),
    .busy(busy), .fault(fault), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    fill_cnt = 0; drain_cnt = 0; ocmd_lo = 0; icmd_lo = 0;
    min_lock = lock_level;
  endtask

  // One cycle: sample at the falling edge, then let the plant respond.
  task automatic tick();
    @(negedge clk);
    cnt[state]++;
    if (fill)  fill_cnt++;
    if (drain) drain_cnt++;
    if (!outer_cmd) ocmd_lo++;
    if (!inner_cmd) icmd_lo++;
    if (lock_level < min_lock) min_lock = lock_level;
    if (fill && drain) viol++;
    if ((fill || drain) && !(outer_closed && inner_closed && outer_cmd && inner_cmd)) viol++;
    if (!outer_cmd && !inner_cmd) viol++;
    if (!freeze) begin
      if (fill)  lock_level = lock_level + 8'd1;
      if (drain) lock_level = lock_level - 8'd1;
    end
    outer_closed = stuck_outer ? 1'b1 : outer_cmd;
    inner_closed = inner_cmd;
  endtask

  task automatic pulse(input logic o, input logic i);
    req_outer = o;
    req_inner = i;
    tick();
    req_outer = 1'b0;
    req_inner = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int limit, input string tag);
    for (int i = 0; i < limit && state !== s; i++) tick();
    chk(tag, state, s);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req_outer = 1'b0; req_inner = 1'b0;
    lock_level = 8'd52; outer_level = 8'd73; inner_level = 8'd49;
    outer_closed = 1'b1; inner_closed = 1'b1;
    freeze = 1'b0; stuck_outer = 1'b0; viol = 0;
    #1 rst = 1'b0;
    clear_counts();
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_outer_cmd", outer_cmd, 1);
    chk("rst_inner_cmd", inner_cmd, 1);
    chk("rst_fill", fill, 0);
    chk("rst_drain", drain, 0);
    chk("rst_grants", {grant_outer, grant_inner}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b1;
    tick();

    // Inner-side transit: drain to 51, inner gate cycle, fill to 71, outer gate cycle.
    clear_counts();
    pulse(1'b0, 1'b1);
    chk("t1_pend_only", grant_inner, 0);
    tick();
    chk("t1_grant", grant_inner, 1);
    chk("t1_eq", state, 1);
    wait_state(4'd0, 3000, "t1_done");
    chk("t1_lock", lock_level, 71);
    chk("t1_min_lock", min_lock, 51);
    chk("t1_eq_cycles", cnt[1], 2);
    chk("t1_dwell_a", cnt[3], 64);
    chk("t1_xfer_cycles", cnt[5], 21);
    chk("t1_dwell_b", cnt[7], 64);
    chk("t1_drains", drain_cnt, 1);
    chk("t1_fills", fill_cnt, 20);
    chk("t1_inner_open", icmd_lo, 65);
    chk("t1_outer_open", ocmd_lo, 65);
    chk("t1_grant_drop", {grant_outer, grant_inner}, 0);
    chk("t1_busy", busy, 0);

    // Simultaneous requests: outer first, inner straight after.
    clear_counts();
    pulse(1'b1, 1'b1);
    chk("t2_pend_only", grant_outer, 0);
    tick();
    chk("t2_first_outer", grant_outer, 1);
    chk("t2_first_not_inner", grant_inner, 0);
    wait_state(4'd0, 3000, "t2_first_done");
    chk("t2_gap_grants", {grant_outer, grant_inner}, 0);
    tick();
    chk("t2_second_inner", grant_inner, 1);
    chk("t2_second_eq", state, 1);
    wait_state(4'd0, 3000, "t2_second_done");
    chk("t2_lock", lock_level, 71);
    chk("t2_drains", drain_cnt, 20);
    chk("t2_fills", fill_cnt, 20);
    chk("t2_min_lock", min_lock, 51);

    // Already matched from the outer side; then the outer gate never reports open.
    lock_level = 8'd72;
    stuck_outer = 1'b1;
    clear_counts();
    pulse(1'b1, 1'b0);
    tick();
    chk("t3_eq", state, 1);
    chk("t3_no_fill", fill, 0);
    chk("t3_no_drain", drain, 0);
    tick();
    chk("t3_open_a", state, 2);
    wait_state(4'd9, 100, "t4_fault_state");
    chk("t4_open_cycles", cnt[2], 17);
    chk("t4_fault", fault, 1);
    chk("t4_cmds", {outer_cmd, inner_cmd}, 2'b11);
    chk("t4_grants", {grant_outer, grant_inner}, 0);
    chk("t4_busy", busy, 1);
    chk("t4_water", {fill, drain}, 0);
    pulse(1'b0, 1'b1);
    repeat (20) tick();
    chk("t4_stuck_state", state, 9);
    chk("t4_stuck_fault", fault, 1);

    // Lock level frozen during transfer: water timeout.
    stuck_outer = 1'b0;
    do_reset();
    chk("t5_reset_fault", fault, 0);
    lock_level = 8'd60; inner_level = 8'd60; freeze = 1'b1;
    clear_counts();
    pulse(1'b0, 1'b1);
    wait_state(4'd5, 500, "t5_xfer");
    wait_state(4'd9, 1200, "t5_fault");
    chk("t5_xfer_cycles", cnt[5], 1025);
    chk("t5_fill_cycles", fill_cnt, 1024);
    chk("t5_fill_off", fill, 0);
    chk("t5_fault_flag", fault, 1);
    chk("t5_lock", lock_level, 60);

    // Reset asserted mid-cycle during the destination dwell.
    do_reset();
    freeze = 1'b0; inner_level = 8'd49; lock_level = 8'd50;
    clear_counts();
    pulse(1'b0, 1'b1);
    wait_state(4'd7, 500, "t6_dwell_b");
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    chk("t6_state", state, 0);
    chk("t6_cmds", {outer_cmd, inner_cmd}, 2'b11);
    chk("t6_busy", busy, 0);
    chk("t6_grants", {grant_outer, grant_inner}, 0);
    chk("t6_water", {fill, drain}, 0);
    chk("t6_fault", fault, 0);
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("t6_idle", state, 0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_outer_closed", outer_closed, 1);

    chk("invariants", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
